// File: rtl/vx_serial_div_ctrl.sv
// Issue/response controller for the multi-cycle serial divider core.
// Optional macro DIV_ZERO_BYPASS_EN: all-zero-divisor requests complete without using the core.
module vx_serial_div_ctrl #(
  parameter int LANES  = 1,
  parameter int WIDTHN = 32,
  parameter int WIDTHD = 32,
  parameter int DATAW  = 32,
  parameter int TAGW   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_signed,
  input  logic                      req_is_rem,
  input  logic [LANES*WIDTHN-1:0]   req_numer,
  input  logic [LANES*WIDTHD-1:0]   req_denom,
  input  logic [TAGW-1:0]           req_tag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [LANES*DATAW-1:0]    rsp_data,
  output logic [TAGW-1:0]           rsp_tag,
  output logic                      div_strobe,
  input  logic                      div_busy,
  output logic                      div_is_signed,
  output logic [LANES*WIDTHN-1:0]   div_numer,
  output logic [LANES*WIDTHD-1:0]   div_denom,
  input  logic [LANES*DATAW-1:0]    div_quotient,
  input  logic [LANES*DATAW-1:0]    div_remainder
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     wait_first;
  logic                     is_rem_r;
  logic [TAGW-1:0]          tag_r;
  logic [LANES*DATAW-1:0]   rsp_data_r;
  logic                     accept;
  logic                     capture;
  logic                     bypass;
  logic [LANES*DATAW-1:0]   bypass_data;

`ifdef DIV_ZERO_BYPASS_EN
  function automatic logic [DATAW-1:0] ext_numer(input logic [WIDTHN-1:0] n, input logic is_signed);
    logic signed [WIDTHN:0] sx;
    sx = {is_signed & n[WIDTHN-1], n};
    return DATAW'(sx);
  endfunction

  // Zero-divisor results are fixed by the ISA, so they can be formed at accept time.
  always_comb begin
    bypass      = 1'b1;
    bypass_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (req_denom[i*WIDTHD +: WIDTHD] != '0) bypass = 1'b0;
      bypass_data[i*DATAW +: DATAW] = req_is_rem ?
        ext_numer(req_numer[i*WIDTHN +: WIDTHN], req_is_signed) : '1;
    end
  end
`else
  assign bypass      = 1'b0;
  assign bypass_data = '0;
`endif

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign div_strobe = (state == START) && !div_busy;
  // The first WAIT cycle is skipped: the core may not have raised busy yet.
  assign capture    = (state == WAIT) && !wait_first && !div_busy;
  assign rsp_valid  = (state == DONE);
  assign rsp_data   = rsp_data_r;
  assign rsp_tag    = tag_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_first <= div_strobe;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bypass ? DONE : START;
      START:   if (!div_busy) state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand and result registers carry no reset; they are qualified by the FSM.
  always_ff @(posedge clk) begin
    if (accept) begin
      div_is_signed <= req_is_signed;
      div_numer     <= req_numer;
      div_denom     <= req_denom;
      is_rem_r      <= req_is_rem;
      tag_r         <= req_tag;
    end
    if (accept && bypass) begin
      rsp_data_r <= bypass_data;
    end else if (capture) begin
      for (int i = 0; i < LANES; i++)
        rsp_data_r[i*DATAW +: DATAW] <= is_rem_r ? div_remainder[i*DATAW +: DATAW]
                                                 : div_quotient[i*DATAW +: DATAW];
    end
  end

endmodule

// File: doc/vx_serial_div_ctrl.md
Name: vx_serial_div_ctrl

Overview:
Upstream issue/response controller for the multi-cycle serial divider core used by the ALU/MDU divide path. It accepts one valid/ready divide request (LANES operand pairs plus a tag), sequences the core's strobe/busy protocol, and captures the selected quotient or remainder per lane. It presents the captured result on a valid/ready response port.

Parameters:
LANES, 1, number of parallel lanes per request
WIDTHN, 32, numerator width; also the core iteration count
WIDTHD, 32, denominator width
DATAW, 32, result width; quotient and remainder are both DATAW
TAGW, 8, opaque request tag width, returned unchanged

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_is_signed  in  1  signed divide
req_is_rem  in  1  1 = return remainder, 0 = return quotient
req_numer  in  LANES*WIDTHN  numerators
req_denom  in  LANES*WIDTHD  denominators
req_tag  in  TAGW  request tag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  LANES*DATAW  selected result per lane
rsp_tag  out  TAGW  tag of the request
div_strobe  out  1  one-cycle start pulse to the core
div_busy  in  1  core busy
div_is_signed  out  1  to core, registered
div_numer  out  LANES*WIDTHN  to core, registered
div_denom  out  LANES*WIDTHD  to core, registered
div_quotient  in  LANES*DATAW  from core
div_remainder  in  LANES*DATAW  from core

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, div_strobe=0. req_ready=1 once reset deasserts.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On accept: register is_signed, is_rem, numer, denom and tag; go to START.
- START:
  - div_strobe = !div_busy.
  - If div_busy=1, hold in START. This protects against a core still busy after a controller reset.
  - When the strobe is issued, go to WAIT.
- WAIT:
  - Ignore the first cycle, in which div_busy is still rising.
  - Afterwards, when div_busy=0: capture rsp_data[i] = is_rem ? div_remainder[i] : div_quotient[i]; go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_tag are held stable until rsp_ready.
  - On handshake go to IDLE.
- Backpressure: req_ready=0 in START, WAIT and DONE. There is one request in flight, with no overlap.
- Latency: accept at cycle T → strobe at T+1 → core busy T+2..T+1+WIDTHN → capture at T+2+WIDTHN → rsp_valid at T+3+WIDTHN (35 cycles for WIDTHN=32).
- Throughput: one request per WIDTHN+4 cycles when rsp_ready is tied high.
- Operand stability: div_* operand outputs change only on request accept.
- Arithmetic: the core owns all arithmetic. Signed results follow RISC-V rules:
  - x/0 → all-ones quotient, remainder = x.
  - MIN/-1 → quotient MIN, remainder 0.
- Async reset mid-operation: controller returns to IDLE and any result is dropped, with no rsp_valid. The next request stalls in START until div_busy=0.
- rsp_valid with rsp_ready held low: stays asserted indefinitely, with data unchanged.

Optional Feature:
Macro: DIV_ZERO_BYPASS_EN
- Defined:
  - If every lane's denom==0 at accept, go straight from IDLE to DONE with no strobe.
  - rsp_data[i] = is_rem ? numer[i] (truncated/extended to DATAW) : all-ones.
  - rsp_valid at T+1.
- Not defined: zero divisors go through the core with normal latency and produce the same values.
- The response value is identical either way; only latency differs.

Test Plan:
- Unsigned 100/7, is_rem=0, tag=0x5A → rsp_data=14, rsp_tag=0x5A, rsp_valid exactly WIDTHN+3 cycles after accept; the same request with is_rem=1 → 2.
- Signed -100/7 → quotient 0xFFFFFFF2 (-14); remainder 0xFFFFFFFE (-2). Signed 0x80000000/-1 → quotient 0x80000000, remainder 0.
- 0x1234/0, unsigned and signed → quotient 0xFFFFFFFF, remainder 0x1234. Latency is 1 with DIV_ZERO_BYPASS_EN and WIDTHN+3 without it.
- rsp_ready held low 10 cycles → rsp_valid, rsp_data and rsp_tag stable, req_ready=0 throughout; second request accepted the cycle after the handshake.
- Async reset asserted 5 cycles into WAIT, then a new request 2 cycles after release while the core is still busy → no stale rsp_valid; strobe delayed until div_busy=0; correct result for the new request.
- LANES=4, lanes {100/7, 9/3, 5/10, 0xFFFFFFFF/1} unsigned → {14, 3, 0, 0xFFFFFFFF}; back-to-back requests with rsp_ready=1 complete every WIDTHN+4 cycles.
